vga_fetch: RTL
==============

// Module: vga_fetch
// PURPOSE
//   Upstream feeder for the vga display controller. Services its 48-bit pixel-group read
//   requests (vga_sel/vga_addr -> vga_data/vga_valid) by issuing three 16-bit reads to the
//   video memory port and packing them into one word. A one-entry hit buffer returns a
//   repeated address without touching memory. Single clock domain (system clk).
// PARAMETERS
//   MEM_AW     22   video memory word-address width
//   BASE_ADDR  0    video memory word address of pixel group 0
// PORTS
//   clk        in   1       system clock; all logic on rising edge
//   rst        in   1       synchronous reset, active-low (0 = reset)
//   vga_sel    in   1       read request, level; held until vga_valid
//   vga_addr   in   20      pixel-group index; stable while vga_sel high
//   vga_data   out  48      packed read data; valid only with vga_valid
//   vga_valid  out  1       one-cycle response strobe
//   flush      in   1       invalidate hit buffer (frame swap); one-cycle pulse
//   mem_req    out  1       memory read request, held until mem_ack
//   mem_addr   out  MEM_AW  memory word address; stable while mem_req high
//   mem_ack    in   1       read accepted; mem_rdata valid in the same cycle
//   mem_rdata  in   16      memory read data
// BEHAVIOUR
//   Reset (rst==0 at an edge): state=IDLE; mem_req=0, mem_addr=0, vga_valid=0, vga_data=0,
//     buf_valid=0, buf_addr=0. An in-flight memory read is abandoned: mem_req drops at that
//     edge and a mem_ack arriving later is ignored.
//   Address arithmetic: mem_addr = BASE_ADDR + vga_addr*3 + beat (beat 0..2), computed
//     at MEM_AW bits; overflow wraps modulo 2^MEM_AW.
//   Packing: beat0 -> vga_data[47:32], beat1 -> [31:16], beat2 -> [15:0].
//   FSM: IDLE, RD0, RD1, RD2, RESP.
//     IDLE: if vga_sel && buf_valid && vga_addr==buf_addr && !flush -> RESP (hit).
//           Else if vga_sel -> RD0: latch the address; mem_req=1, mem_addr=beat 0.
//     RDn:  hold mem_req and mem_addr until mem_ack.
//           On ack: capture mem_rdata; RD0->RD1 and RD1->RD2 (mem_addr advances, mem_req
//           stays 1, no bubble). RD2->RESP, and mem_req drops.
//           On leaving RD2: buf_addr=latched address, buf_valid=1.
//     RESP: vga_valid=1 for exactly one cycle, vga_data=buffer contents; -> IDLE.
//   Latency: hit = vga_valid one cycle after vga_sel is sampled in IDLE.
//     Miss = 1 + (cycles to 3 acks); with mem_ack tied high, vga_valid 4 cycles after
//     the request is sampled.
//   Requester rule: drop vga_sel on the cycle after vga_valid. The block samples vga_sel
//     only in IDLE, so one request never receives two responses.
//   Abort: if vga_sel falls during RDn, the fetch still completes and fills the buffer.
//     RESP is skipped (vga_valid stays 0), and the FSM returns to IDLE.
//   flush: clears buf_valid at the edge. If flush coincides with a hit lookup, flush wins
//     and the lookup is a miss. If flush arrives during RDn, the buffer filled by that
//     fetch is still marked valid, because the fetch reads post-flush memory.
//   mem_ack is ignored in IDLE and RESP.
//   vga_data holds its last value outside vga_valid.
// TESTING
//   1 Reset: hold rst=0 for 3 clk -> mem_req=0, vga_valid=0, vga_data=0. Then vga_sel=1,
//     vga_addr=0 -> mem_addr 0,1,2.
//   2 Miss, mem_ack=1 always, vga_addr=20'h00010, rdata=16'hA1A1/B2B2/C3C3 -> mem_addr
//     48,49,50; vga_valid 4 cycles later; vga_data=48'hA1A1B2B2C3C3.
//   3 Repeat addr 20'h00010 -> no mem_req; vga_valid next cycle, same data. flush=1 in
//     the request cycle -> full 3-beat refetch.
//   4 Wait states: mem_ack high only every 3rd cycle -> mem_addr stable while mem_req is
//     high; exactly 3 acks consumed; data packed in order.
//   5 Wrap: BASE_ADDR=22'h3FFFFE, vga_addr=0 -> mem_addr 3FFFFE, 3FFFFF, 000000.
//   6 Reset at RD1 then release; next request addr 5 -> mem_addr restarts at 15.
//     Abort: vga_sel dropped in RD1 -> no vga_valid, buffer filled, re-request hits.

Source files
------------

// File: rtl/vga_fetch.sv
// vga_fetch: pixel-group read feeder for the vga display controller.
// Each 48-bit request becomes three 16-bit video memory reads, which are
// packed into one word. A one-entry buffer answers a repeated group index
// without going to memory.
// Ports:
//   clk, rst           system clock, synchronous active-low reset
//   vga_sel/vga_addr   level request + pixel-group index (held until vga_valid)
//   vga_data/vga_valid packed response + one-cycle strobe
//   flush              one-cycle pulse, invalidates the hit buffer
//   mem_req/mem_addr   memory read request (held until mem_ack) + word address
//   mem_ack/mem_rdata  read accept + data, same cycle
module vga_fetch #(
    parameter int                MEM_AW    = 22,
    parameter logic [MEM_AW-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_sel,
    input  logic [19:0]       vga_addr,
    output logic [47:0]       vga_data,
    output logic              vga_valid,
    input  logic              flush,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_RD2, S_RESP} state_t;

    state_t            r_state;
    logic [19:0]       r_addr;       // group index of the fetch in flight
    logic [19:0]       r_buf_addr;
    logic              r_buf_valid;
    logic [47:0]       r_buf_data;   // assembled in place, beat by beat
    logic              r_abort;      // requester let go of vga_sel mid-fetch

    logic [MEM_AW-1:0] w_addr0;
    logic              w_hit;
    logic              w_abort;

    // Three words per group; arithmetic wraps at MEM_AW bits.
    assign w_addr0 = BASE_ADDR + MEM_AW'(vga_addr) * MEM_AW'(3);
    // A flush in the lookup cycle forces a miss.
    assign w_hit   = vga_sel && r_buf_valid && (vga_addr == r_buf_addr) && !flush;
    assign w_abort = r_abort || !vga_sel;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            vga_valid   <= 1'b0;
            vga_data    <= '0;
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
            r_addr      <= '0;
            r_abort     <= 1'b0;
        end else begin
            vga_valid <= 1'b0;
            if (flush) r_buf_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_state   <= S_RESP;
                        vga_valid <= 1'b1;
                        vga_data  <= r_buf_data;
                    end else if (vga_sel) begin
                        r_state     <= S_RD0;
                        r_addr      <= vga_addr;
                        mem_req     <= 1'b1;
                        mem_addr    <= w_addr0;
                        r_abort     <= 1'b0;
                        // buffer data is about to be overwritten beat by beat
                        r_buf_valid <= 1'b0;
                    end
                end
                S_RD0: begin
                    if (!vga_sel) r_abort <= 1'b1;
                    if (mem_ack) begin
                        r_buf_data[47:32] <= mem_rdata;
                        mem_addr          <= mem_addr + MEM_AW'(1);
                        r_state           <= S_RD1;
                    end
                end
                S_RD1: begin
                    if (!vga_sel) r_abort <= 1'b1;
                    if (mem_ack) begin
                        r_buf_data[31:16] <= mem_rdata;
                        mem_addr          <= mem_addr + MEM_AW'(1);
                        r_state           <= S_RD2;
                    end
                end
                S_RD2: begin
                    if (!vga_sel) r_abort <= 1'b1;
                    if (mem_ack) begin
                        r_buf_data[15:0] <= mem_rdata;
                        mem_req          <= 1'b0;
                        // fetch read post-flush memory, so it is valid even if a
                        // flush arrived during the fetch (overrides the clear above)
                        r_buf_valid      <= 1'b1;
                        r_buf_addr       <= r_addr;
                        if (w_abort) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state   <= S_RESP;
                            vga_valid <= 1'b1;
                            vga_data  <= {r_buf_data[47:16], mem_rdata};
                        end
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
